// File: rtl/snake_engine_if.sv
// Bundle between the game controller and snake_engine: control, target and
// pixel-query inputs, plus head/length/status and query results back.
interface snake_engine_if #(
  parameter int unsigned H_W   = 8,
  parameter int unsigned V_W   = 7,
  parameter int unsigned LEN_W = 6
);
  logic             run;
  logic             restart;
  logic [1:0]       dir;
  logic [H_W-1:0]   target_h;
  logic [V_W-1:0]   target_v;
  logic [H_W-1:0]   pix_h;
  logic [V_W-1:0]   pix_v;
  logic             hit;
  logic             head_hit;
  logic [H_W-1:0]   head_h;
  logic [V_W-1:0]   head_v;
  logic [LEN_W-1:0] length;
  logic             reached;
  logic             dead;

  modport master (
    output run, restart, dir, target_h, target_v, pix_h, pix_v,
    input  hit, head_hit, head_h, head_v, length, reached, dead
  );

  modport slave (
    input  run, restart, dir, target_h, target_v, pix_h, pix_v,
    output hit, head_hit, head_h, head_v, length, reached, dead
  );
endinterface

// File: rtl/snake_engine.sv
// Snake movement/collision engine: body kept as a shift register of grid cells,
// advanced once per TICK_DIV cycles while running, grown on target hits.
module snake_engine #(
  parameter int unsigned H_CELLS  = 160,
  parameter int unsigned V_CELLS  = 120,
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter bit          WRAP     = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  snake_engine_if.slave bus
);
  localparam int unsigned H_W   = $clog2(H_CELLS);
  localparam int unsigned V_W   = $clog2(V_CELLS);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_CELLS - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_CELLS - 1);
  localparam logic [V_W-1:0]   V_MID    = V_W'(V_CELLS / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       dir_q;
  logic [LEN_W-1:0] len_q;
  logic [H_W-1:0]   seg_h_q [MAX_LEN];
  logic [V_W-1:0]   seg_v_q [MAX_LEN];
  logic             reached_q;
  logic             hit_q;
  logic             head_hit_q;

  logic [1:0]       step_dir;
  logic [H_W-1:0]   next_h;
  logic [V_W-1:0]   next_v;
  logic             wall_hit;
  logic             target_hit;
  logic             extend;
  logic             self_hit;
  logic [LEN_W-1:0] cmp_len;
  logic             hit_d;
  logic             head_hit_d;

  // Initial body: horizontal line ending at the grid centre, head rightmost.
  // Indices beyond INIT_LEN are not live, so their wrapped values are harmless.
  function automatic logic [H_W-1:0] init_h(input int unsigned idx);
    return H_W'(H_CELLS / 2 - idx);
  endfunction

  // Next head cell from the (reverse-filtered) direction, with edge handling.
  always_comb begin
    step_dir = ((bus.dir ^ dir_q) == 2'b10) ? dir_q : bus.dir;
    next_h   = seg_h_q[0];
    next_v   = seg_v_q[0];
    wall_hit = 1'b0;
    unique case (step_dir)
      DIR_UP: begin
        if (seg_v_q[0] == '0) begin
          next_v   = V_LAST;
          wall_hit = !WRAP;
        end else begin
          next_v = seg_v_q[0] - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (seg_h_q[0] == H_LAST) begin
          next_h   = '0;
          wall_hit = !WRAP;
        end else begin
          next_h = seg_h_q[0] + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (seg_v_q[0] == V_LAST) begin
          next_v   = '0;
          wall_hit = !WRAP;
        end else begin
          next_v = seg_v_q[0] + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (seg_h_q[0] == '0) begin
          next_h   = H_LAST;
          wall_hit = !WRAP;
        end else begin
          next_h = seg_h_q[0] - 1'b1;
        end
      end
    endcase
  end

  // Growth and self-collision: the tail cell only counts when eating, since
  // otherwise it vacates on the same step.
  always_comb begin
    target_hit = (next_h == bus.target_h) && (next_v == bus.target_v);
    extend     = target_hit && (len_q < LEN_W'(MAX_LEN));
    cmp_len    = target_hit ? len_q : len_q - 1'b1;
    self_hit   = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < cmp_len) && (seg_h_q[i] == next_h) && (seg_v_q[i] == next_v)) begin
        self_hit = 1'b1;
      end
    end
  end

  // Pixel query against the live segments.
  always_comb begin
    hit_d      = 1'b0;
    head_hit_d = (seg_h_q[0] == bus.pix_h) && (seg_v_q[0] == bus.pix_v);
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < len_q) && (seg_h_q[i] == bus.pix_h) && (seg_v_q[i] == bus.pix_v)) begin
        hit_d = 1'b1;
      end
    end
  end

  // Game state, move tick and body shift register; restart beats a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_q      <= DIR_RIGHT;
      len_q      <= LEN_W'(INIT_LEN);
      reached_q  <= 1'b0;
      hit_q      <= 1'b0;
      head_hit_q <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_h_q[i] <= init_h(i);
        seg_v_q[i] <= V_MID;
      end
    end else begin
      reached_q  <= 1'b0;
      hit_q      <= hit_d;
      head_hit_q <= head_hit_d;
      if (bus.restart) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        dir_q   <= DIR_RIGHT;
        len_q   <= LEN_W'(INIT_LEN);
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          seg_h_q[i] <= init_h(i);
          seg_v_q[i] <= V_MID;
        end
      end else if (state_q != ST_DEAD) begin
        if (!bus.run) begin
          state_q <= ST_IDLE;
        end else begin
          state_q <= ST_MOVE;
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (wall_hit || self_hit) begin
              state_q <= ST_DEAD;
            end else begin
              dir_q      <= step_dir;
              reached_q  <= target_hit;
              seg_h_q[0] <= next_h;
              seg_v_q[0] <= next_v;
              for (int i = 1; i < int'(MAX_LEN); i++) begin
                seg_h_q[i] <= seg_h_q[i-1];
                seg_v_q[i] <= seg_v_q[i-1];
              end
              if (extend) begin
                len_q <= len_q + 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.hit      = hit_q;
  assign bus.head_hit = head_hit_q;
  assign bus.head_h   = seg_h_q[0];
  assign bus.head_v   = seg_v_q[0];
  assign bus.length   = len_q;
  assign bus.reached  = reached_q;
  assign bus.dead     = (state_q == ST_DEAD);
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine on an 8x8 grid: a wrapping instance driven
// from a vector table, and a non-wrapping instance for wall death.
module tb_snake_engine;
  typedef struct {
    logic       run;
    logic       restart;
    logic [1:0] dir;
    logic [2:0] tgt_h, tgt_v, pix_h, pix_v;
    int         cycles;
    logic [2:0] head_h, head_v, len;
    logic       reached, dead, hit, head_hit;
  } vec_t;

  localparam int NVEC = 22;

  vec_t vecs [NVEC];
  int   n_cmp = 0;
  int   n_err = 0;
  logic clk = 1'b0;
  logic rst_n;

  snake_engine_if #(.H_W(3), .V_W(3), .LEN_W(3)) bus_w ();
  snake_engine_if #(.H_W(3), .V_W(3), .LEN_W(3)) bus_n ();

  snake_engine #(
    .H_CELLS(8), .V_CELLS(8), .MAX_LEN(4), .INIT_LEN(3), .TICK_DIV(4), .WRAP(1'b1)
  ) dut_w (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_w)
  );

  snake_engine #(
    .H_CELLS(8), .V_CELLS(8), .MAX_LEN(4), .INIT_LEN(3), .TICK_DIV(4), .WRAP(1'b0)
  ) dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int run, input int rs, input int dir, input int th,
                              input int tv, input int ph, input int pv, input int cyc,
                              input int hh, input int hv, input int len, input int rch,
                              input int dead, input int hit, input int hhit);
    vec_t v;
    v.run      = 1'(run);
    v.restart  = 1'(rs);
    v.dir      = 2'(dir);
    v.tgt_h    = 3'(th);
    v.tgt_v    = 3'(tv);
    v.pix_h    = 3'(ph);
    v.pix_v    = 3'(pv);
    v.cycles   = cyc;
    v.head_h   = 3'(hh);
    v.head_v   = 3'(hv);
    v.len      = 3'(len);
    v.reached  = 1'(rch);
    v.dead     = 1'(dead);
    v.hit      = 1'(hit);
    v.head_hit = 1'(hhit);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int hh, input int hv, input int len,
                       input int rch, input int dead, input int hit, input int hhit);
    check({tag, ".head_h"},   32'(bus_w.head_h),   32'(hh));
    check({tag, ".head_v"},   32'(bus_w.head_v),   32'(hv));
    check({tag, ".length"},   32'(bus_w.length),   32'(len));
    check({tag, ".reached"},  32'(bus_w.reached),  32'(rch));
    check({tag, ".dead"},     32'(bus_w.dead),     32'(dead));
    check({tag, ".hit"},      32'(bus_w.hit),      32'(hit));
    check({tag, ".head_hit"}, 32'(bus_w.head_hit), 32'(hhit));
  endtask

  task automatic chk_n(input string tag, input int hh, input int hv, input int len,
                       input int rch, input int dead, input int hit, input int hhit);
    check({tag, ".head_h"},   32'(bus_n.head_h),   32'(hh));
    check({tag, ".head_v"},   32'(bus_n.head_v),   32'(hv));
    check({tag, ".length"},   32'(bus_n.length),   32'(len));
    check({tag, ".reached"},  32'(bus_n.reached),  32'(rch));
    check({tag, ".dead"},     32'(bus_n.dead),     32'(dead));
    check({tag, ".hit"},      32'(bus_n.hit),      32'(hit));
    check({tag, ".head_hit"}, 32'(bus_n.head_hit), 32'(hhit));
  endtask

  task automatic drive_w(input logic run, input logic rs, input logic [1:0] dir,
                         input logic [2:0] th, input logic [2:0] tv,
                         input logic [2:0] ph, input logic [2:0] pv);
    bus_w.run      = run;
    bus_w.restart  = rs;
    bus_w.dir      = dir;
    bus_w.target_h = th;
    bus_w.target_v = tv;
    bus_w.pix_h    = ph;
    bus_w.pix_v    = pv;
  endtask

  task automatic drive_n(input logic run, input logic [1:0] dir,
                         input logic [2:0] ph, input logic [2:0] pv);
    bus_n.run      = run;
    bus_n.restart  = 1'b0;
    bus_n.dir      = dir;
    bus_n.target_h = 3'd0;
    bus_n.target_v = 3'd0;
    bus_n.pix_h    = ph;
    bus_n.pix_v    = pv;
  endtask

  initial begin
    //           run rs dir th tv ph pv cyc  hh hv len rch dead hit hhit
    vecs[0]  = mk(1, 0, 1, 0, 0, 3, 4, 4,   5, 4, 3, 0, 0, 1, 0);  // first step after 4 edges
    vecs[1]  = mk(1, 0, 1, 0, 0, 5, 4, 4,   6, 4, 3, 0, 0, 1, 1);
    vecs[2]  = mk(1, 0, 1, 0, 0, 0, 0, 4,   7, 4, 3, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 7, 4, 4,   0, 4, 3, 0, 0, 1, 1);  // wrap right edge
    vecs[4]  = mk(1, 0, 1, 1, 4, 6, 4, 4,   1, 4, 4, 1, 0, 1, 0);  // grow
    vecs[5]  = mk(1, 0, 1, 2, 4, 6, 4, 1,   1, 4, 4, 0, 0, 1, 0);  // reached drops
    vecs[6]  = mk(1, 0, 1, 2, 4, 6, 4, 3,   2, 4, 4, 1, 0, 1, 0);  // hit at MAX_LEN
    vecs[7]  = mk(1, 0, 1, 0, 0, 6, 4, 1,   2, 4, 4, 0, 0, 0, 0);  // old tail vacated
    vecs[8]  = mk(1, 0, 3, 0, 0, 0, 0, 3,   3, 4, 4, 0, 0, 0, 0);  // reverse ignored
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 4,   3, 3, 4, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 1, 0, 0, 0, 0, 1,   4, 4, 3, 0, 0, 0, 0);  // restart
    vecs[11] = mk(1, 0, 3, 0, 0, 0, 0, 4,   5, 4, 3, 0, 0, 0, 0);  // reverse ignored
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 4,   5, 3, 3, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 6, 3, 0, 0, 4,   6, 3, 4, 1, 0, 0, 0);
    vecs[14] = mk(1, 0, 2, 0, 0, 0, 0, 4,   6, 4, 4, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 3, 0, 0, 0, 0, 4,   5, 4, 4, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 5, 3, 6, 3, 4,   5, 4, 4, 0, 1, 1, 0);  // into own tail while eating
    vecs[17] = mk(1, 0, 0, 0, 0, 5, 4, 20,  5, 4, 4, 0, 1, 1, 1);  // frozen
    vecs[18] = mk(0, 1, 1, 0, 0, 0, 0, 1,   4, 4, 3, 0, 0, 0, 0);  // restart from dead
    vecs[19] = mk(1, 0, 1, 0, 0, 2, 4, 2,   4, 4, 3, 0, 0, 1, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 2, 4, 10,  4, 4, 3, 0, 0, 1, 0);  // paused, counter holds
    vecs[21] = mk(1, 0, 1, 0, 0, 2, 4, 2,   5, 4, 3, 0, 0, 1, 0);

    // Reset values, reached asynchronously before any clock edge.
    drive_w(1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd4, 3'd4);
    drive_n(1'b0, 2'b01, 3'd0, 3'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_w("reset_w", 4, 4, 3, 0, 0, 0, 0);
    chk_n("reset_n", 4, 4, 3, 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NVEC; k++) begin
      drive_w(vecs[k].run, vecs[k].restart, vecs[k].dir, vecs[k].tgt_h, vecs[k].tgt_v,
              vecs[k].pix_h, vecs[k].pix_v);
      repeat (vecs[k].cycles) @(negedge clk);
      chk_w($sformatf("v%0d", k), 32'(vecs[k].head_h), 32'(vecs[k].head_v),
            32'(vecs[k].len), 32'(vecs[k].reached), 32'(vecs[k].dead),
            32'(vecs[k].hit), 32'(vecs[k].head_hit));
    end
    drive_w(1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd0, 3'd0);

    // No-wrap instance: walks to the right edge and dies stepping off it.
    drive_n(1'b1, 2'b01, 3'd0, 3'd0);
    repeat (12) @(negedge clk);
    chk_n("wall_edge", 7, 4, 3, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk_n("wall_dead", 7, 4, 3, 0, 1, 0, 0);
    drive_n(1'b1, 2'b01, 3'd7, 3'd4);
    @(negedge clk);
    chk_n("wall_q_head", 7, 4, 3, 0, 1, 1, 1);
    drive_n(1'b1, 2'b01, 3'd0, 3'd0);
    @(negedge clk);
    chk_n("wall_q_empty", 7, 4, 3, 0, 1, 0, 0);
    repeat (8) @(negedge clk);
    chk_n("wall_frozen", 7, 4, 3, 0, 1, 0, 0);

    // Reset dropped one edge before a step that would have reached the target.
    drive_w(1'b0, 1'b1, 2'b01, 3'd5, 3'd4, 3'd4, 3'd4);
    @(negedge clk);
    chk_w("pre_restart", 4, 4, 3, 0, 0, 1, 0);
    drive_w(1'b1, 1'b0, 2'b01, 3'd5, 3'd4, 3'd4, 3'd4);
    repeat (3) @(negedge clk);
    chk_w("pre_abort", 4, 4, 3, 0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_w("async_w", 4, 4, 3, 0, 0, 0, 0);
    chk_n("async_n", 4, 4, 3, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d.reached", c), 32'(bus_w.reached), 32'd0);
      check($sformatf("post_rst%0d.head_h", c), 32'(bus_w.head_h), 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
